// File: rtl/arbitro_pulsadores_if.sv
// rtl/arbitro_pulsadores_if.sv - offer/accept handshake between the button arbiter and its consumer
interface arbitro_pulsadores_if;
  logic       valido;
  logic       listo;
  logic [1:0] codigo;

  modport master (output valido, output codigo, input listo);
  modport slave  (input valido, input codigo, output listo);
endinterface

// File: rtl/arbitro_pulsadores.sv
// rtl/arbitro_pulsadores.sv - four-button press arbiter with sticky overflow flags
// Presses become pending events; one pending channel at a time is offered to the consumer.
module arbitro_pulsadores #(
  parameter int PRIORIDAD_FIJA = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [3:0]                  botones,
  input  logic                        borrar_desborde,
  arbitro_pulsadores_if.master        hs,
  output logic [3:0]                  pendientes,
  output logic [3:0]                  desborde
);

  localparam logic [0:0] ESPERA = 1'b0;
  localparam logic [0:0] OFRECE = 1'b1;

  logic [0:0] estado;
  logic [3:0] botones_prev;
  logic [1:0] puntero;
  logic [1:0] codigo_r;
  logic [1:0] ganador;
  logic [1:0] base;
  logic [1:0] idx;
  logic       hallado;
  logic [3:0] flanco;
  logic [3:0] aceptado_mask;
  logic [3:0] perdido;
  logic       acepta;

  assign flanco        = botones & ~botones_prev;
  assign acepta        = (estado == OFRECE) & hs.listo;
  assign aceptado_mask = acepta ? (4'b0001 << codigo_r) : 4'b0000;
  // A press on a channel still pending (and not leaving this edge) is lost.
  assign perdido       = flanco & pendientes & ~aceptado_mask;

  assign hs.valido = (estado == OFRECE);
  assign hs.codigo = codigo_r;

  // Fixed priority is a round-robin search that always starts after channel 3.
  always_comb begin
    base    = (PRIORIDAD_FIJA != 0) ? 2'd3 : puntero;
    ganador = 2'd0;
    hallado = 1'b0;
    idx     = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = base + 2'(k);
      if (!hallado && pendientes[idx]) begin
        ganador = idx;
        hallado = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado       <= ESPERA;
      codigo_r     <= 2'd0;
      puntero      <= 2'd3;
      pendientes   <= 4'b0000;
      desborde     <= 4'b0000;
      botones_prev <= 4'b1111;
    end else begin
      botones_prev <= botones;
      pendientes   <= (pendientes & ~aceptado_mask) | flanco;
      desborde     <= (borrar_desborde ? 4'b0000 : desborde) | perdido;
      if (estado == ESPERA) begin
        if (|pendientes) begin
          estado   <= OFRECE;
          codigo_r <= ganador;
          if (PRIORIDAD_FIJA == 0) puntero <= ganador;
        end
      end else begin
        if (hs.listo) estado <= ESPERA;
      end
    end
  end

endmodule
